// File: rtl/xlr8_dm_pkg.sv
// xlr8_dm_pkg: shared state type, limits and helpers for the AVR data-memory bank
package xlr8_dm_pkg;
  localparam int DM_MAX_KB = 64;
  localparam int DM_LAT_MAX = 2;
  typedef enum logic {DM_CLEAR, DM_IDLE} dm_state_t;
  function automatic int dm_adr_width(input int dm_size, input int width);
    return $clog2(dm_size * 1024 / (width / 8));
  endfunction
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/xlr8_dm_array.sv
// xlr8_dm_array: single-port RAM, registered address, per-lane write enables, 1-cycle read
module xlr8_dm_array #(
  parameter int AW = 10,
  parameter int LW = 8,
  parameter int NL = 1
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    a,
  input  logic [NL-1:0]    we,
  input  logic [NL*LW-1:0] wd,
  output logic [NL*LW-1:0] rd
);
`ifdef XLR8_DM_M9K
`ifdef D_MEM_SIM_MODEL
  localparam bit HW = 1'b0;
`else
  localparam bit HW = 1'b1;
`endif
`else
  localparam bit HW = 1'b0;
`endif
  logic [NL*LW-1:0] mem [2**AW];
  logic [AW-1:0] a_q;
  if (!HW) begin : g_sim
    always_ff @(posedge clk) begin
      if (en) a_q <= a;
      for (int i = 0; i < NL; i++)
        if (we[i]) mem[a][i*LW +: LW] <= wd[i*LW +: LW];
    end
    assign rd = mem[a_q];
  end
`ifdef XLR8_DM_M9K
  if (HW) begin : g_m9k
    altsyncram #(
      .operation_mode("SINGLE_PORT"),
      .width_a(NL*LW),
      .widthad_a(AW),
      .numwords_a(2**AW),
      .width_byteena_a(NL),
      .byte_size(LW),
      .outdata_reg_a("UNREGISTERED"),
      .read_during_write_mode_port_a("NEW_DATA_WITH_NBE_READ"),
      .intended_device_family("Cyclone IV E"),
      .lpm_type("altsyncram")
    ) u_ram (
      .clock0(clk),
      .clocken0(1'b1),
      .address_a(a),
      .addressstall_a(~en),
      .wren_a(|we),
      .byteena_a(we),
      .data_a(wd),
      .q_a(rd)
    );
  end
`endif
endmodule

// File: rtl/xlr8_dm_bank.sv
// xlr8_dm_bank: AVR data-memory bank with clear sweep, 1/2-cycle reads and range flag
// Optional per-byte even parity when XLR8_DM_PARITY_EN is defined
module xlr8_dm_bank
  import xlr8_dm_pkg::*;
#(
  parameter int DM_SIZE = 1,
  parameter int WIDTH = 8,
  parameter int RD_LAT = 1
) (
  input  logic               cp2,
  input  logic               rst,
  input  logic               ce,
  input  logic [15:0]        address,
  input  logic [WIDTH-1:0]   din,
  input  logic [WIDTH/8-1:0] be,
  input  logic               we,
  input  logic               re,
  output logic               ready,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  input  logic               clr_req,
  output logic               busy,
  output logic               oor,
  output logic               parity_err
);
  localparam int NBE = WIDTH / 8;
  localparam int AW = dm_adr_width(DM_SIZE, WIDTH);
`ifdef XLR8_DM_PARITY_EN
  localparam int LW = 9;
`else
  localparam int LW = 8;
`endif
  dm_state_t state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic clearing, in_rng, acc, rd_acc, wr_acc;
  logic [NBE-1:0] ram_we, lane_bad;
  logic [NBE*LW-1:0] ram_wd, ram_rd, rd_raw, hold_q;
  logic s1_v_q, s1_oor_q, held_q, s1_perr;
  logic [WIDTH-1:0] s1_dat, o_d, dout_q;
  logic o_v, o_perr, dout_valid_q, oor_q, parity_err_q;
  assign clearing = state_q == DM_CLEAR;
  assign busy = clearing;
  assign ready = ~clearing;
  assign in_rng = (address >> AW) == 16'd0;
  assign acc = ready & ce & (re | we);
  assign rd_acc = acc & re;
  assign wr_acc = acc & we & in_rng;
  // the sweep ends by wrapping the counter, so IDLE always holds it at zero
  always_comb begin
    state_d = clearing ? (&clr_cnt_q ? DM_IDLE : DM_CLEAR) : (clr_req ? DM_CLEAR : DM_IDLE);
    clr_cnt_d = clearing ? clr_cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge cp2 or posedge rst)
    if (rst) begin
      state_q <= DM_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  assign ram_we = clearing ? {NBE{1'b1}} : (wr_acc ? be : '0);
  xlr8_dm_array #(.AW(AW), .LW(LW), .NL(NBE)) u_arr (
    .clk(cp2),
    .en(clearing | acc),
    .a(clearing ? clr_cnt_q : address[AW-1:0]),
    .we(ram_we),
    .wd(ram_wd),
    .rd(ram_rd)
  );
  // a stalled read keeps its RAM word here since a clear sweep may move the RAM address
  always_ff @(posedge cp2 or posedge rst)
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_oor_q <= 1'b0;
      held_q <= 1'b0;
      hold_q <= '0;
    end else if (ce) begin
      s1_v_q <= rd_acc;
      s1_oor_q <= ~in_rng;
      held_q <= 1'b0;
    end else if (s1_v_q && !held_q) begin
      held_q <= 1'b1;
      hold_q <= ram_rd;
    end
  assign rd_raw = held_q ? hold_q : ram_rd;
`ifdef XLR8_DM_PARITY_EN
  logic [NBE-1:0] s1_be_q;
  always_ff @(posedge cp2 or posedge rst)
    if (rst) s1_be_q <= '0;
    else if (rd_acc) s1_be_q <= be;
`endif
  for (genvar i = 0; i < NBE; i++) begin : g_lane
`ifdef XLR8_DM_PARITY_EN
    assign ram_wd[i*LW +: LW] = clearing ? '0 : {byte_parity(din[i*8 +: 8]), din[i*8 +: 8]};
    assign lane_bad[i] = s1_be_q[i] & ^rd_raw[i*LW +: LW];
`else
    assign ram_wd[i*LW +: LW] = clearing ? '0 : din[i*8 +: 8];
    assign lane_bad[i] = 1'b0;
`endif
    assign s1_dat[i*8 +: 8] = s1_oor_q ? 8'h00 : rd_raw[i*LW +: 8];
  end
  assign s1_perr = ~s1_oor_q & |lane_bad;
  if (RD_LAT == 2) begin : g_lat2
    logic s2_v_q, s2_perr_q;
    logic [WIDTH-1:0] s2_d_q;
    always_ff @(posedge cp2 or posedge rst)
      if (rst) begin
        s2_v_q <= 1'b0;
        s2_perr_q <= 1'b0;
        s2_d_q <= '0;
      end else if (ce) begin
        s2_v_q <= s1_v_q;
        s2_perr_q <= s1_v_q & s1_perr;
        if (s1_v_q) s2_d_q <= s1_dat;
      end
    assign o_v = s2_v_q;
    assign o_d = s2_d_q;
    assign o_perr = s2_perr_q;
  end else begin : g_lat1
    assign o_v = s1_v_q;
    assign o_d = s1_dat;
    assign o_perr = s1_perr;
  end
  always_ff @(posedge cp2 or posedge rst)
    if (rst) begin
      dout_q <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      dout_valid_q <= ce & o_v;
      parity_err_q <= ce & o_v & o_perr;
      oor_q <= acc & ~in_rng;
      if (ce && o_v) dout_q <= o_d;
    end
  assign dout = dout_q;
  assign dout_valid = dout_valid_q;
  assign oor = oor_q;
  assign parity_err = parity_err_q;
endmodule

// File: tb/tb_xlr8_dm_bank.sv
// tb_xlr8_dm_bank: scoreboard bench for an 8-bit/1-cycle bank and a 16-bit/2-cycle bank
module tb_xlr8_dm_bank;
  typedef struct {logic [15:0] d; int t; logic p;} exp_t;
  logic cp2 = 1'b0, rst = 1'b1;
  always #5 cp2 = ~cp2;
  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge cp2) cyc <= cyc + 1;
  logic a_ce, a_we, a_re, a_clr, a_ready, a_dv, a_busy, a_oor, a_perr;
  logic [15:0] a_adr;
  logic [7:0] a_din, a_dout;
  logic [0:0] a_be;
  logic b_ce, b_we, b_re, b_clr, b_ready, b_dv, b_busy, b_oor, b_perr;
  logic [15:0] b_adr, b_din, b_dout;
  logic [1:0] b_be;
  logic [7:0] ma [1024];
  logic [15:0] mb [512];
  exp_t qa[$], qb[$];
  xlr8_dm_bank u_a (
    .cp2(cp2), .rst(rst), .ce(a_ce), .address(a_adr), .din(a_din), .be(a_be),
    .we(a_we), .re(a_re), .ready(a_ready), .dout(a_dout), .dout_valid(a_dv),
    .clr_req(a_clr), .busy(a_busy), .oor(a_oor), .parity_err(a_perr)
  );
  xlr8_dm_bank #(.DM_SIZE(1), .WIDTH(16), .RD_LAT(2)) u_b (
    .cp2(cp2), .rst(rst), .ce(b_ce), .address(b_adr), .din(b_din), .be(b_be),
    .we(b_we), .re(b_re), .ready(b_ready), .dout(b_dout), .dout_valid(b_dv),
    .clr_req(b_clr), .busy(b_busy), .oor(b_oor), .parity_err(b_perr)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge cp2) begin
    exp_t e;
    if (a_dv) begin
      if (qa.size() == 0) check("a_spurious_valid", 32'(a_dv), 0);
      else begin
        e = qa.pop_front();
        check("a_dout", 32'(a_dout), 32'(e.d));
        check("a_latency", cyc, e.t);
        check("a_parity_err", 32'(a_perr), 32'(e.p));
      end
    end
    if (b_dv) begin
      if (qb.size() == 0) check("b_spurious_valid", 32'(b_dv), 0);
      else begin
        e = qb.pop_front();
        check("b_dout", 32'(b_dout), 32'(e.d));
        check("b_latency", cyc, e.t);
        check("b_parity_err", 32'(b_perr), 32'(e.p));
      end
    end
  end
  // called at a negedge; drives one request for one cycle, assuming it is accepted
  task automatic a_op(input logic w, input logic r, input logic [15:0] adr, input logic [7:0] d);
    logic [7:0] e;
    a_we = w; a_re = r; a_adr = adr; a_din = d;
    if (w && adr < 16'd1024) ma[adr[9:0]] = d;
    e = adr < 16'd1024 ? ma[adr[9:0]] : 8'h00;
    if (r) qa.push_back('{{8'h00, e}, cyc + 2, 1'b0});
    @(negedge cp2);
    a_we = 1'b0; a_re = 1'b0;
  endtask
  task automatic b_op(input logic w, input logic r, input logic [15:0] adr, input logic [15:0] d,
                      input logic [1:0] be, input int extra);
    logic [15:0] e;
    b_we = w; b_re = r; b_adr = adr; b_din = d; b_be = be;
    if (w && adr < 16'd512)
      for (int i = 0; i < 2; i++) if (be[i]) mb[adr[8:0]][i*8 +: 8] = d[i*8 +: 8];
    e = adr < 16'd512 ? mb[adr[8:0]] : 16'h0000;
    if (r) qb.push_back('{e, cyc + 3 + extra, 1'b0});
    @(negedge cp2);
    b_we = 1'b0; b_re = 1'b0;
  endtask
  task automatic sweep(input int ea, input int eb);
    int ka = 0, kb = 0;
    fork
      while (a_busy && ka < 5000) begin
        @(negedge cp2);
        ka++;
        a_clr = ka == 100;
      end
      while (b_busy && kb < 5000) begin
        @(negedge cp2);
        kb++;
      end
    join
    a_clr = 1'b0;
    check("a_sweep_len", ka, ea);
    check("b_sweep_len", kb, eb);
    if (ea > 0) ma = '{default: 8'h00};
    if (eb > 0) mb = '{default: 16'h0000};
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    a_ce = 1; a_we = 0; a_re = 0; a_clr = 0; a_adr = 0; a_din = 0; a_be = 1'b1;
    b_ce = 1; b_we = 0; b_re = 0; b_clr = 0; b_adr = 0; b_din = 0; b_be = 2'b11;
    ma = '{default: 8'h00};
    mb = '{default: 16'h0000};
    repeat (3) @(negedge cp2);
    check("rst_busy", 32'(a_busy), 1);
    check("rst_ready", 32'(a_ready), 0);
    check("rst_valid", 32'(a_dv), 0);
    check("rst_dout", 32'(a_dout), 0);
    check("rst_oor", 32'(a_oor), 0);
    check("rst_parity", 32'(a_perr), 0);
    check("rst_b_dout", 32'(b_dout), 0);
    rst = 1'b0;
    sweep(1024, 512);
    check("a_ready_after_sweep", 32'(a_ready), 1);
    a_op(0, 1, 16'h03FF, 0);
    b_op(0, 1, 16'h01FF, 0, 2'b11, 0);
    b_op(1, 0, 16'h0010, 16'h12AB, 2'b11, 0);
    b_op(1, 0, 16'h0010, 16'hFF00, 2'b10, 0);
    b_op(0, 1, 16'h0010, 0, 2'b11, 0);
    for (int i = 0; i < 3; i++) b_op(1, 0, 16'(i), 16'h1111 * 16'(i + 1), 2'b11, 0);
    for (int i = 0; i < 3; i++) b_op(0, 1, 16'(i), 0, 2'b11, 0);
    repeat (4) @(negedge cp2);
    b_op(0, 1, 16'h0000, 0, 2'b11, 1);
    b_op(0, 1, 16'h0001, 0, 2'b11, 1);
    b_ce = 1'b0; b_re = 1'b1; b_adr = 16'h0002;
    @(negedge cp2);
    b_ce = 1'b1; b_re = 1'b0;
    b_op(0, 1, 16'h0002, 0, 2'b11, 0);
    a_op(1, 0, 16'h0000, 8'h33);
    a_op(1, 1, 16'h0005, 8'h5A);
    a_op(1, 0, 16'h0006, 8'h77);
    a_op(0, 1, 16'h0006, 0);
    repeat (2) @(negedge cp2);
    check("a_dout_hold", 32'(a_dout), 32'h77);
    check("a_valid_low", 32'(a_dv), 0);
    a_ce = 1'b0; a_we = 1'b1; a_re = 1'b1; a_adr = 16'h0005; a_din = 8'hFF;
    @(negedge cp2);
    a_ce = 1'b1; a_we = 1'b0; a_re = 1'b0;
    a_op(0, 1, 16'h0005, 0);
    a_op(1, 0, 16'h0400, 8'hEE);
    check("a_oor_write", 32'(a_oor), 1);
    a_op(0, 1, 16'h0400, 0);
    check("a_oor_read", 32'(a_oor), 1);
    a_op(0, 1, 16'h0000, 0);
    check("a_oor_inrange", 32'(a_oor), 0);
    a_op(1, 0, 16'h0007, 8'h99);
    a_clr = 1'b1;
    a_op(0, 1, 16'h0007, 0);
    a_clr = 1'b0;
    check("a_clr_busy", 32'(a_busy), 1);
    check("a_clr_ready", 32'(a_ready), 0);
    sweep(1024, 0);
    a_op(0, 1, 16'h0007, 0);
    a_op(1, 0, 16'h0009, 8'h42);
    a_op(0, 1, 16'h0009, 0);
    repeat (3) @(negedge cp2);
    a_clr = 1'b1;
    @(negedge cp2);
    a_clr = 1'b0;
    repeat (300) @(negedge cp2);
    check("a_mid_sweep_busy", 32'(a_busy), 1);
    rst = 1'b1;
    #1;
    check("a_rst_dout", 32'(a_dout), 0);
    @(negedge cp2);
    rst = 1'b0;
    sweep(1024, 512);
    a_op(0, 1, 16'h0009, 0);
    b_op(0, 1, 16'h0010, 0, 2'b11, 0);
`ifdef XLR8_DM_PARITY_EN
    a_op(1, 0, 16'h0003, 8'h0F);
    u_a.u_arr.mem[3][0] = ~u_a.u_arr.mem[3][0];
    a_re = 1'b1; a_adr = 16'h0003;
    qa.push_back('{16'h000E, cyc + 2, 1'b1});
    @(negedge cp2);
    a_re = 1'b0;
`endif
    repeat (6) @(negedge cp2);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
